ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
- Bus-side writer for the SAP RAM: takes a byte stream over a valid/ready handshake and programs RAM words 0..WORDS-1 in order.
- Each word is written through the RAM's address-register load strobe, then its write strobe.
- Sits between the serial/byte front end and the shared 8-bit bus; the RAM itself is the responder.

Parameters:
DATA_W, 8, bus and RAM word width
ADDR_W, 4, RAM address width
WORDS, 16, words per session; must be in 1..2**ADDR_W

Ports:
clk  in  1  system clock, rising edge
clear_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begins a load session from IDLE
abort  in  1  aborts the session, returns to IDLE
in_data  in  DATA_W  byte to program
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts a byte
bus_in  in  DATA_W  bus readback from RAM (used only with VERIFY_EN)
bus_out  out  DATA_W  value driven onto bus
bus_drive  out  1  loader owns bus (tri-state enable upstream)
load_addr_reg  out  1  RAM MAR load strobe
write_enable  out  1  RAM write strobe
output_enable  out  1  RAM read strobe
prog_mode  out  1  high for the whole session; selects bus-sourced addressing/data in RAM
busy  out  1  session in progress
done  out  1  one-cycle pulse, session complete
error  out  1  sticky verify mismatch

Behaviour:
- Reset (clear_n low, async): state IDLE, addr 0, checksum 0. All outputs 0 immediately: bus_out, strobes, in_ready, busy, done, error.
- FSM states: IDLE, WAIT_BYTE, SET_ADDR, WRITE, and with VERIFY_EN also V_ADDR, V_READ, V_SAMPLE, CHECK. All outputs are registered or decoded from state only; no input-to-output combinational paths.
- IDLE: on start go to WAIT_BYTE. Clear addr and checksum. Clear error.
- WAIT_BYTE: in_ready=1. On in_valid&&in_ready, capture in_data and go to SET_ADDR. in_ready is 0 in every other state.
- SET_ADDR: bus_drive=1, bus_out=zero-extended addr, load_addr_reg=1 for exactly 1 cycle. Then go to WRITE.
- WRITE: bus_drive=1, bus_out=captured byte, write_enable=1 for exactly 1 cycle. checksum += byte, mod 2**DATA_W.
  - If addr==WORDS-1: go to DONE path.
  - Otherwise addr++ and return to WAIT_BYTE.
- Throughput: 3 cycles per byte minimum (accept, address, write).
- Write strobes are one-hot: load_addr_reg, write_enable and output_enable are never high together.
- busy and prog_mode are high in every state except IDLE.
- done pulses high in the cycle the FSM re-enters IDLE after a successful final step.
- abort: highest priority outside reset. Next state IDLE, strobes low next cycle, no done pulse, RAM contents already written are kept.
- start while busy is ignored. start and abort together in IDLE: abort wins (stay IDLE).
- The address counter never wraps: a session ends at WORDS-1.

Optional Feature:
- Macro: SAP_RAM_LOADER_VERIFY_EN.
- Defined: after the last WRITE, addr=0 and checksum2=0, then for each word:
  - V_ADDR: load_addr_reg with addr, bus driven by loader.
  - V_READ: output_enable=1, bus_drive=0.
  - V_SAMPLE: output_enable held, checksum2 += bus_in.
  - Then addr++ or, after WORDS-1, go to CHECK.
- CHECK: error<=(checksum2!=checksum), sticky until next start. done pulses regardless of result.
- Not defined: verify states absent, output_enable and error tied 0, bus_in ignored.

Decomposition:
- Package sap_pkg holds: SAP_DATA_W=8, SAP_ADDR_W=4, the loader state enum typedef, and a word typedef.
- One sub-module: ram_loader_csum, a DATA_W modulo accumulator with clear/add, instantiated twice under VERIFY_EN and once otherwise.

Test Plan:
- Reset mid-WRITE (clear_n low at write_enable high): all outputs 0 within the same timestep. After release, state IDLE and in_ready=0.
- start, then 16 bytes 8'h00..8'h0F with in_valid held: load_addr_reg pulses carry bus_out 0..15 and write_enable pulses carry data 0..15. done pulses once at cycle 49 ±1 after start; RAM model holds mem[i]==i.
- Throttled source (in_valid every 5th cycle): in_ready high only in WAIT_BYTE, no byte lost or duplicated, and the RAM image matches the sent bytes.
- abort after 7 bytes: strobes low the next cycle, no done, busy=0. RAM words 0..6 written, 7..15 untouched. A new start restarts at address 0.
- VERIFY_EN with RAM model corrupting word 9 (stores 8'hAA for 8'h09): done pulses and error=1. With a clean model, error=0.
- start pulsed during a session plus WORDS=1 build: extra start has no effect. WORDS=1 session ends after one write and addr never exceeds 0.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared SAP definitions: bus/address widths, loader state encoding and word type.
// The readback states exist only when SAP_RAM_LOADER_VERIFY_EN is defined.
package sap_pkg;

  localparam int SAP_DATA_W = 8;
  localparam int SAP_ADDR_W = 4;

  typedef logic [SAP_DATA_W-1:0] sap_word_t;

`ifdef SAP_RAM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BYTE = 3'd1,
    ST_SET_ADDR  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_V_ADDR    = 3'd4,
    ST_V_READ    = 3'd5,
    ST_V_SAMPLE  = 3'd6,
    ST_CHECK     = 3'd7
  } loader_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BYTE = 3'd1,
    ST_SET_ADDR  = 3'd2,
    ST_WRITE     = 3'd3
  } loader_state_e;
`endif

endpackage

// File: rtl/ram_loader_csum.sv
// Modulo-2**DATA_W running sum with synchronous clear and add enable.
module ram_loader_csum
  import sap_pkg::*;
#(
  parameter int DATA_W = SAP_DATA_W
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              clr,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_val,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] sum_r;

  // accumulator register; clear takes precedence over add
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sum_r <= {DATA_W{1'b0}};
    end else if (clr) begin
      sum_r <= {DATA_W{1'b0}};
    end else if (add_en) begin
      sum_r <= sum_r + add_val;
    end else begin
      sum_r <= sum_r;
    end
  end

  assign sum = sum_r;

endmodule

// File: rtl/ram_loader.sv
// ram_loader: programs SAP RAM words 0..WORDS-1 from a valid/ready byte stream.
// Define SAP_RAM_LOADER_VERIFY_EN to add a readback checksum pass after the writes.
module ram_loader
  import sap_pkg::*;
#(
  parameter int DATA_W = SAP_DATA_W,
  parameter int ADDR_W = SAP_ADDR_W,
  parameter int WORDS  = 16
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  output logic              load_addr_reg,
  output logic              write_enable,
  output logic              output_enable,
  output logic              prog_mode,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  loader_state_e     state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] byte_r, byte_s;
  logic              done_r, done_s;
  logic              csum_clr_s, csum_add_s;
  logic [DATA_W-1:0] csum_s;

  ram_loader_csum #(.DATA_W(DATA_W)) u_csum (
    .clk     (clk),
    .clear_n (clear_n),
    .clr     (csum_clr_s),
    .add_en  (csum_add_s),
    .add_val (byte_r),
    .sum     (csum_s)
  );

`ifdef SAP_RAM_LOADER_VERIFY_EN
  logic              error_r, error_s;
  logic              csum2_clr_s, csum2_add_s;
  logic [DATA_W-1:0] csum2_s;

  ram_loader_csum #(.DATA_W(DATA_W)) u_csum2 (
    .clk     (clk),
    .clear_n (clear_n),
    .clr     (csum2_clr_s),
    .add_en  (csum2_add_s),
    .add_val (bus_in),
    .sum     (csum2_s)
  );
`else
  // without readback the write checksum and bus readback have no consumer
  logic unused_s;
  assign unused_s = ^{csum_s, bus_in};
`endif

  // next-state logic; abort overrides every state
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    byte_s     = byte_r;
    done_s     = 1'b0;
    csum_clr_s = 1'b0;
    csum_add_s = 1'b0;
`ifdef SAP_RAM_LOADER_VERIFY_EN
    error_s     = error_r;
    csum2_clr_s = 1'b0;
    csum2_add_s = 1'b0;
`endif
    if (abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_s    = ST_WAIT_BYTE;
            addr_s     = {ADDR_W{1'b0}};
            csum_clr_s = 1'b1;
`ifdef SAP_RAM_LOADER_VERIFY_EN
            error_s    = 1'b0;
`endif
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_WAIT_BYTE: begin
          // in_ready is high throughout this state, so in_valid alone completes the handshake
          if (in_valid) begin
            byte_s  = in_data;
            state_s = ST_SET_ADDR;
          end else begin
            state_s = ST_WAIT_BYTE;
          end
        end
        ST_SET_ADDR: begin
          state_s = ST_WRITE;
        end
        ST_WRITE: begin
          csum_add_s = 1'b1;
          if (addr_r == LAST_ADDR) begin
`ifdef SAP_RAM_LOADER_VERIFY_EN
            state_s     = ST_V_ADDR;
            addr_s      = {ADDR_W{1'b0}};
            csum2_clr_s = 1'b1;
`else
            state_s = ST_IDLE;
            done_s  = 1'b1;
`endif
          end else begin
            addr_s  = addr_r + ADDR_W'(1'b1);
            state_s = ST_WAIT_BYTE;
          end
        end
`ifdef SAP_RAM_LOADER_VERIFY_EN
        ST_V_ADDR: begin
          state_s = ST_V_READ;
        end
        ST_V_READ: begin
          state_s = ST_V_SAMPLE;
        end
        ST_V_SAMPLE: begin
          csum2_add_s = 1'b1;
          if (addr_r == LAST_ADDR) begin
            state_s = ST_CHECK;
          end else begin
            addr_s  = addr_r + ADDR_W'(1'b1);
            state_s = ST_V_ADDR;
          end
        end
        ST_CHECK: begin
          error_s = (csum2_s != csum_s);
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end
`endif
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // state, address, captured byte and done pulse registers
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_r <= ST_IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      byte_r  <= {DATA_W{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      byte_r  <= byte_s;
      done_r  <= done_s;
    end
  end

`ifdef SAP_RAM_LOADER_VERIFY_EN
  // sticky verify result, cleared when a new session starts
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      error_r <= 1'b0;
    end else begin
      error_r <= error_s;
    end
  end

  assign error = error_r;
`else
  assign error = 1'b0;
`endif

  // bus and strobe decode from the registered state only
  always_comb begin
    in_ready      = 1'b0;
    bus_out       = {DATA_W{1'b0}};
    bus_drive     = 1'b0;
    load_addr_reg = 1'b0;
    write_enable  = 1'b0;
    output_enable = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b0;
      end
      ST_WAIT_BYTE: begin
        in_ready = 1'b1;
      end
      ST_SET_ADDR: begin
        bus_drive     = 1'b1;
        bus_out       = DATA_W'(addr_r);
        load_addr_reg = 1'b1;
      end
      ST_WRITE: begin
        bus_drive    = 1'b1;
        bus_out      = byte_r;
        write_enable = 1'b1;
      end
`ifdef SAP_RAM_LOADER_VERIFY_EN
      ST_V_ADDR: begin
        bus_drive     = 1'b1;
        bus_out       = DATA_W'(addr_r);
        load_addr_reg = 1'b1;
      end
      ST_V_READ: begin
        output_enable = 1'b1;
      end
      ST_V_SAMPLE: begin
        output_enable = 1'b1;
      end
      ST_CHECK: begin
        output_enable = 1'b0;
      end
`endif
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign busy      = (state_r != ST_IDLE);
  assign prog_mode = (state_r != ST_IDLE);
  assign done      = done_r;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: RAM model, stream source and event scoreboard.
module tb_ram_loader;

  localparam int NW = 16;
`ifdef SAP_RAM_LOADER_VERIFY_EN
  localparam int DONE_LAT = 6 * NW + 2;
`else
  localparam int DONE_LAT = 3 * NW + 1;
`endif

  logic       clk = 1'b0;
  logic       clear_n, start, abort, in_valid;
  logic [7:0] in_data, bus_in;
  logic       in_ready, bus_drive, load_addr_reg, write_enable, output_enable;
  logic       prog_mode, busy, done, error;
  logic [7:0] bus_out;

  logic       s_start, s_valid, s_ready, s_drive, s_load, s_we, s_oe, s_pm, s_busy, s_done, s_err;
  logic [7:0] s_data, s_bus_in, s_bus_out;

  always #5 clk = ~clk;

  ram_loader dut (
    .clk(clk), .clear_n(clear_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bus_in(bus_in), .bus_out(bus_out), .bus_drive(bus_drive),
    .load_addr_reg(load_addr_reg), .write_enable(write_enable),
    .output_enable(output_enable), .prog_mode(prog_mode),
    .busy(busy), .done(done), .error(error)
  );

  ram_loader #(.WORDS(1)) dut_one (
    .clk(clk), .clear_n(clear_n), .start(s_start), .abort(1'b0),
    .in_data(s_data), .in_valid(s_valid), .in_ready(s_ready),
    .bus_in(s_bus_in), .bus_out(s_bus_out), .bus_drive(s_drive),
    .load_addr_reg(s_load), .write_enable(s_we),
    .output_enable(s_oe), .prog_mode(s_pm),
    .busy(s_busy), .done(s_done), .error(s_err)
  );

  // RAM model and event recorder
  logic [7:0] mem [NW];
  logic [7:0] exp_mem [NW];
  logic [3:0] mar;
  logic       corrupt, preset_req;
  int         cyc, start_cyc, done_cyc, done_cnt;
  int         oh_err, rdy_err, pm_err, drv_err, oe_cnt;
  int         s_load_cnt, s_load_bad, s_we_cnt;
  logic [7:0] acc_q[$], addr_q[$], wdata_q[$];

  always_comb bus_in = output_enable ? mem[mar] : 8'h00;
  assign s_bus_in = 8'h00;

  always @(posedge clk) begin
    if (preset_req) begin
      for (int i = 0; i < NW; i++) mem[i] <= 8'(8'hE0 + i);
    end
    if (clear_n) begin
      cyc <= cyc + 1;
      if (start && !busy && !abort) start_cyc <= cyc + 1;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc + 1;
      end
      if (in_valid && in_ready) acc_q.push_back(in_data);
      if (load_addr_reg) begin
        mar <= bus_out[3:0];
        if (!bus_drive) drv_err <= drv_err + 1;
      end
      if (write_enable) begin
        mem[mar] <= (corrupt && mar == 4'd9) ? 8'hAA : bus_out;
        addr_q.push_back({4'h0, mar});
        wdata_q.push_back(bus_out);
        if (!bus_drive) drv_err <= drv_err + 1;
      end
      if ($countones({load_addr_reg, write_enable, output_enable}) > 1) oh_err <= oh_err + 1;
      if (in_ready && (load_addr_reg || write_enable || output_enable || bus_drive || !busy))
        rdy_err <= rdy_err + 1;
      if (busy != prog_mode) pm_err <= pm_err + 1;
      if (output_enable) oe_cnt <= oe_cnt + 1;
      if (s_load) begin
        s_load_cnt <= s_load_cnt + 1;
        if (s_bus_out != 8'h00) s_load_bad <= s_load_bad + 1;
      end
      if (s_we) s_we_cnt <= s_we_cnt + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic preset();
    preset_req = 1'b1;
    @(negedge clk); preset_req = 1'b0;
    for (int i = 0; i < NW; i++) exp_mem[i] = 8'(8'hE0 + i);
    addr_q.delete(); wdata_q.delete();
  endtask

  // offers bytes every `period` cycles, holding each until accepted
  task automatic feed(input logic [7:0] b[$], input int period);
    int base = acc_q.size();
    int c = 0;
    int prev = 0;
    int got = 0;
    in_valid = 1'b0;
    while ((acc_q.size() - base) < b.size() && c < 600) begin
      @(negedge clk); c++;
      got = acc_q.size() - base;
      if (got != prev) begin in_valid = 1'b0; prev = got; end
      if (!in_valid && got < b.size() && (c % period) == 0) begin
        in_valid = 1'b1; in_data = b[got];
      end
    end
    in_valid = 1'b0;
    chk("bytes_accepted", acc_q.size() - base, b.size());
  endtask

  task automatic wait_done(input string tag);
    int d0 = done_cnt;
    int c = 0;
    while (done_cnt == d0 && c < 300) begin @(negedge clk); c++; end
    tick(4);
    chk(tag, done_cnt - d0, 1);
  endtask

  task automatic check_stream(input string tag, input logic [7:0] b[$]);
    int bad = 0;
    for (int i = 0; i < b.size() && i < wdata_q.size(); i++)
      if (addr_q[i] !== 8'(i) || wdata_q[i] !== b[i]) bad++;
    chk({tag, "_nwrites"}, wdata_q.size(), b.size());
    chk({tag, "_order"}, bad, 0);
  endtask

  task automatic check_image(input string tag);
    int bad = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  logic [7:0] seq[$], rnd[$], part[$];
  int lat, d0;

  initial begin
    clear_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    s_start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    corrupt = 1'b0; preset_req = 1'b0; mar = 4'h0;
    cyc = 0; start_cyc = 0; done_cyc = 0; done_cnt = 0;
    oh_err = 0; rdy_err = 0; pm_err = 0; drv_err = 0; oe_cnt = 0;
    s_load_cnt = 0; s_load_bad = 0; s_we_cnt = 0;
    for (int i = 0; i < NW; i++) seq.push_back(8'(i));
    tick(3);
    chk("rst_outputs", int'({bus_out, bus_drive, load_addr_reg, write_enable, output_enable,
                             in_ready, busy, prog_mode, done, error}), 0);
    clear_n = 1'b1;
    tick(2);
    chk("idle_ready", int'({in_ready, busy, done}), 0);

    // sequential 0..15 with in_valid held
    preset();
    for (int i = 0; i < NW; i++) exp_mem[i] = seq[i];
    pulse_start();
    feed(seq, 1);
    wait_done("a_done");
    lat = done_cyc - start_cyc;
    chk("a_latency", int'(lat >= DONE_LAT - 1 && lat <= DONE_LAT + 1), 1);
    check_stream("a", seq);
    check_image("a_image");
    chk("a_error", int'(error), 0);

    // throttled random source, with start held high mid-session
    preset();
    for (int i = 0; i < NW; i++) rnd.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < NW; i++) exp_mem[i] = rnd[i];
    pulse_start();
    start = 1'b1;
    feed(rnd, 5);
    start = 1'b0;
    wait_done("b_done");
    check_stream("b", rnd);
    check_image("b_image");

    // abort after seven bytes
    preset();
    for (int i = 0; i < 7; i++) begin
      part.push_back(8'($urandom_range(0, 255)));
      exp_mem[i] = part[i];
    end
    d0 = done_cnt;
    pulse_start();
    feed(part, 1);
    for (int c = 0; c < 20 && wdata_q.size() < 7; c++) tick(1);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_outputs", int'({load_addr_reg, write_enable, output_enable, bus_drive, busy, prog_mode}), 0);
    tick(10);
    chk("abort_no_done", done_cnt - d0, 0);
    check_stream("abort", part);
    check_image("abort_image");
    addr_q.delete(); wdata_q.delete();
    pulse_start();
    feed(rnd, 1);
    wait_done("restart_done");
    check_stream("restart", rnd);

`ifdef SAP_RAM_LOADER_VERIFY_EN
    // readback with word 9 corrupted, then clean
    preset();
    corrupt = 1'b1;
    for (int i = 0; i < NW; i++) exp_mem[i] = seq[i];
    exp_mem[9] = 8'hAA;
    pulse_start();
    feed(seq, 1);
    wait_done("v_bad_done");
    check_image("v_bad_image");
    chk("v_bad_error", int'(error), 1);
    tick(5);
    chk("v_error_sticky", int'(error), 1);
    corrupt = 1'b0;
    preset();
    for (int i = 0; i < NW; i++) exp_mem[i] = seq[i];
    pulse_start();
    chk("v_error_cleared", int'(error), 0);
    feed(seq, 1);
    wait_done("v_ok_done");
    chk("v_ok_error", int'(error), 0);
`else
    chk("no_output_enable", oe_cnt, 0);
    chk("no_error", int'(error), 0);
`endif

    // reset asserted while write_enable is high
    pulse_start();
    in_data = 8'($urandom_range(0, 255)); in_valid = 1'b1;
    for (int c = 0; c < 20 && !write_enable; c++) tick(1);
    chk("midwrite_reached", int'(write_enable), 1);
    #1 clear_n = 1'b0;
    #1 chk("midwrite_reset_outputs", int'({bus_out, bus_drive, load_addr_reg, write_enable,
                                           output_enable, in_ready, busy, prog_mode, done, error}), 0);
    in_valid = 1'b0;
    @(negedge clk); clear_n = 1'b1;
    tick(2);
    chk("post_reset_idle", int'({in_ready, busy}), 0);

    // single-word instance
    s_valid = 1'b1; s_data = 8'h5A;
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    for (int c = 0; c < 20 && !s_done; c++) tick(1);
    chk("one_done", int'(s_done), 1);
    tick(5);
    chk("one_writes", s_we_cnt, 1);
    chk("one_loads", s_load_cnt, 1);
    chk("one_addr_zero", s_load_bad, 0);
    chk("one_idle", int'(s_busy), 0);
    s_valid = 1'b0;

    chk("strobes_onehot", oh_err, 0);
    chk("ready_only_wait", rdy_err, 0);
    chk("prog_mode_eq_busy", pm_err, 0);
    chk("strobe_bus_driven", drv_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
